array_masked_1r1w: RTL

ARRAY_MASKED_1R1W -- requirements
Module: array_masked_1r1w

---
 rtl/array_pkg.sv | 18 +
 rtl/array_init_seq.sv | 52 +++++
 rtl/array_masked_1r1w.sv | 110 +++++++++++
 3 files changed

// File: rtl/array_pkg.sv
// Shared types and helpers for the masked 1R1W array: controller states, lane width, byte parity.
// Latency: none (declarations only).
// Backpressure: not applicable.
package array_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam int LANE_W = 8;

    // Even parity: the stored bit makes the total number of ones in lane+bit even.
    function automatic logic byte_parity(input logic [LANE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/array_init_seq.sv
// Post-reset clear sequencer: walks every address once, then reports init_done.
// Latency: clear takes exactly 2**ADDR_W cycles after reset deasserts.
// Backpressure: none; the array ignores user traffic until init_done_o is high.
module array_init_seq
    import array_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] clr_addr_o,
    output logic              clr_we_o,
    output logic              init_done_o
);

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              clr_we_q;
    logic              init_done_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            clr_we_q    <= 1'b1;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + ADDR_W'(1);
                    // The edge that clears the last address also hands over to READY.
                    if (cnt_q == '1) begin
                        state_q     <= ST_READY;
                        clr_we_q    <= 1'b0;
                        init_done_q <= 1'b1;
                    end
                end
                ST_READY: begin
                    state_q <= ST_READY;
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign clr_addr_o  = cnt_q;
    assign clr_we_o    = clr_we_q;
    assign init_done_o = init_done_q;

endmodule

// File: rtl/array_masked_1r1w.sv
// Byte-masked 1R1W array with self-clear after reset and write-first forwarding; optional ARRAY_PARITY_EN.
// Latency: read data and R0_valid one cycle after R0_en.
// Backpressure: none; requests are dropped while init_done is low, R0_data holds when R0_en is low.
module array_masked_1r1w
    import array_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     W0_en,
    input  logic [ADDR_W-1:0]        W0_addr,
    input  logic [DATA_W-1:0]        W0_data,
    input  logic [DATA_W/LANE_W-1:0] W0_mask,
    input  logic                     R0_en,
    input  logic [ADDR_W-1:0]        R0_addr,
    output logic [DATA_W-1:0]        R0_data,
    output logic                     R0_valid,
    output logic [DATA_W/LANE_W-1:0] R0_perr,
    output logic                     init_done
);

    localparam int MASK_W = DATA_W / LANE_W;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
`ifdef ARRAY_PARITY_EN
    logic [MASK_W-1:0] par_q [DEPTH];
`endif

    logic [ADDR_W-1:0] clr_addr;
    logic              clr_we;
    logic              ready;
    logic              rd_fire;
    logic              wr_fire;
    logic [MASK_W-1:0] fwd;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rdata_d, rdata_q;
    logic [MASK_W-1:0] perr_d, perr_q;
    logic              rvalid_q;

    array_init_seq #(.ADDR_W(ADDR_W)) u_init_seq (
        .clock       (clock),
        .reset       (reset),
        .clr_addr_o  (clr_addr),
        .clr_we_o    (clr_we),
        .init_done_o (init_done)
    );

    // A reset edge must not let a stale READY state accept one last access.
    assign ready   = init_done & ~reset;
    assign rd_fire = ready & R0_en;
    assign wr_fire = ready & W0_en;

    always_comb begin
        rd_word = mem_q[R0_addr];
        fwd     = (wr_fire && (W0_addr == R0_addr)) ? W0_mask : '0;
        rdata_d = rdata_q;
        perr_d  = perr_q;
        if (rd_fire) begin
            for (int i = 0; i < MASK_W; i++) begin
                rdata_d[i*LANE_W +: LANE_W] = fwd[i] ? W0_data[i*LANE_W +: LANE_W]
                                                     : rd_word[i*LANE_W +: LANE_W];
`ifdef ARRAY_PARITY_EN
                perr_d[i] = ~fwd[i] &
                            (byte_parity(rd_word[i*LANE_W +: LANE_W]) ^ par_q[R0_addr][i]);
`else
                perr_d[i] = 1'b0;
`endif
            end
        end
    end

    // Storage is never reset directly; the clear sequencer zeroes it instead.
    always_ff @(posedge clock) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
`ifdef ARRAY_PARITY_EN
            par_q[clr_addr] <= '0;
`endif
        end else if (wr_fire) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (W0_mask[i]) begin
                    mem_q[W0_addr][i*LANE_W +: LANE_W] <= W0_data[i*LANE_W +: LANE_W];
`ifdef ARRAY_PARITY_EN
                    par_q[W0_addr][i] <= byte_parity(W0_data[i*LANE_W +: LANE_W]);
`endif
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q  <= '0;
            perr_q   <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            perr_q   <= perr_d;
            rvalid_q <= rd_fire;
        end
    end

    assign R0_data  = rdata_q;
    assign R0_valid = rvalid_q;
    assign R0_perr  = perr_q;

endmodule
